// File: rtl/rstseq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// State encoding is exposed on state_dbg, so the enum order is part of the interface.
package rstseq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } rstseq_state_t;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_NUM_STAGES     = 3;
  localparam int DEF_STAGE_GAP      = 64;
  localparam int DEF_MAX_RETRIES    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; output resets low.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage shift; blocking would collapse them into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases domain resets in order.
// Define PLL_LOCK_RECOVERY_EN to re-sequence automatically when lock drops in RUN.
module pll_reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready,
  output logic                  lock_fail,
  output logic                  lock_lost,
  output logic [2:0]            state_dbg
);

  localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                   max_int(STABLE_CYCLES, NUM_STAGES * STAGE_GAP));
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that saw lock already counts as the first stable cycle.
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0]   FINAL_STAGE  = CNT_W'((NUM_STAGES - 1) * STAGE_GAP);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  rstseq_state_t          state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [RETRY_W-1:0]     retry_cnt, retry_next;
  logic [NUM_STAGES-1:0]  stage_hit, rst_out_next;
  logic                   lock_lost_next;
  logic                   locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    stage_hit = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      stage_hit[k] = (cnt == CNT_W'(k * STAGE_GAP));
  end

  // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    retry_next     = retry_cnt;
    lock_lost_next = lock_lost;
    if (sw_reset_req) begin
      state_next     = PLL_RST;
      retry_next     = '0;
      lock_lost_next = 1'b0;
    end else begin
      case (state)
        PLL_RST:   if (cnt == PLL_RST_LAST) state_next = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_next = retry_cnt + 1'b1;
              state_next = PLL_RST;
            end else begin
              state_next = FAIL;
            end
          end
        end
        STABLE: begin
          if (!locked_s)                state_next = WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_next = RELEASE;
        end
        RELEASE: begin
          if (!locked_s)                state_next = PLL_RST;
          else if (cnt == FINAL_STAGE)  state_next = RUN;
        end
        RUN: begin
          retry_next = '0;
          if (!locked_s) begin
            lock_lost_next = 1'b1;
`ifdef PLL_LOCK_RECOVERY_EN
            state_next     = PLL_RST;
`endif
          end
        end
        FAIL:    state_next = FAIL;
        default: state_next = PLL_RST;
      endcase
    end
  end

  // The counter only measures time inside a state; RUN and FAIL park it at zero.
  always_comb begin
    if (sw_reset_req || (state_next != state) || (state inside {RUN, FAIL}))
      cnt_next = '0;
    else
      cnt_next = cnt + 1'b1;
  end

  always_comb begin
    rst_out_next = '0;
    if (state_next inside {RELEASE, RUN})
      rst_out_next = rst_out_n | ((state == RELEASE) ? stage_hit : '0);
  end

  // NOTE: control state and outputs all reset asynchronously; there is no memory here that would need to skip reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      rst_out_n <= '0;
      ready     <= 1'b0;
      lock_fail <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retry_cnt <= retry_next;
      pll_rst   <= (state_next == PLL_RST);
      rst_out_n <= rst_out_next;
      ready     <= (state_next == RUN);
      lock_fail <= (state_next == FAIL);
      lock_lost <= lock_lost_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer; expected timings come from edge arithmetic on the sequencing rules.
// Honors PLL_LOCK_RECOVERY_EN for the lock-drop scenario.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES = 16;
  localparam int LOCK_TIMEOUT   = 2000;
  localparam int STABLE_CYCLES  = 1024;
  localparam int NUM_STAGES     = 3;
  localparam int STAGE_GAP      = 64;
  localparam int MAX_RETRIES    = 3;

  localparam logic [2:0] ST_PLL_RST = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;
  localparam logic [NUM_STAGES-1:0] ALL_REL    = '1;
  localparam logic [NUM_STAGES-1:0] ALL_RST    = '0;
  localparam logic [NUM_STAGES-1:0] FIRST_ONLY = NUM_STAGES'(1);

  logic                  refclk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  pll_locked = 1'b0;
  logic                  sw_reset_req = 1'b0;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  ready;
  logic                  lock_fail;
  logic                  lock_lost;
  logic [2:0]            state_dbg;

  int errors = 0;
  int checks = 0;
  int rise_at [NUM_STAGES];
  int ready_at;
  int drop_cnt;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .NUM_STAGES     (NUM_STAGES),
    .STAGE_GAP      (STAGE_GAP),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .rst_out_n    (rst_out_n),
    .ready        (ready),
    .lock_fail    (lock_fail),
    .lock_lost    (lock_lost),
    .state_dbg    (state_dbg)
  );

  // Inputs change just after a rising edge; the next rising edge is edge 0 for that change.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic count_pll_rst_high(output int n);
    n = 0;
    for (int i = 0; i < 4 * PLL_RST_CYCLES; i++) begin
      @(negedge refclk);
      if (!pll_rst) break;
      n++;
    end
  endtask

  // Records the edge index (0 = first edge after the call) at which each output first rises.
  task automatic watch_release();
    for (int k = 0; k < NUM_STAGES; k++) rise_at[k] = -1;
    ready_at = -1;
    drop_cnt = 0;
    for (int idx = 0; idx < 2 + STABLE_CYCLES + NUM_STAGES * STAGE_GAP + 32; idx++) begin
      @(posedge refclk);
      @(negedge refclk);
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (rise_at[k] < 0 && rst_out_n[k]) rise_at[k] = idx;
        else if (rise_at[k] >= 0 && !rst_out_n[k]) drop_cnt++;
      end
      if (ready_at < 0 && ready) ready_at = idx;
      if (ready_at >= 0) break;
    end
  endtask

  // Model: 2 synchroniser edges, STABLE_CYCLES qualified cycles, then one stage every STAGE_GAP.
  task automatic check_release(input string tag);
    int want;
    for (int k = 0; k < NUM_STAGES; k++) begin
      want = 2 + STABLE_CYCLES + k * STAGE_GAP;
      checks++;
      if (rise_at[k] != want) begin
        errors++;
        $display("FAIL %s stage%0d release edge: got %0d want %0d", tag, k, rise_at[k], want);
      end
    end
    want = 2 + STABLE_CYCLES + (NUM_STAGES - 1) * STAGE_GAP;
    checks++;
    if (ready_at != want) begin
      errors++;
      $display("FAIL %s ready edge: got %0d want %0d", tag, ready_at, want);
    end
    checks++;
    if (drop_cnt != 0) begin
      errors++;
      $display("FAIL %s released bit dropped: got %0d drops want 0", tag, drop_cnt);
    end
    checks++;
    if ({state_dbg, pll_rst, lock_fail, lock_lost} !== {ST_RUN, 3'b000}) begin
      errors++;
      $display("FAIL %s run status {state,pll_rst,fail,lost}: got %b want %b",
               tag, {state_dbg, pll_rst, lock_fail, lock_lost}, {ST_RUN, 3'b000});
    end
  endtask

  task automatic run_to_run(input int d, input string tag);
    int n;
    count_pll_rst_high(n);
    checks++;
    if (n != PLL_RST_CYCLES) begin
      errors++;
      $display("FAIL %s pll_rst width: got %0d want %0d", tag, n, PLL_RST_CYCLES);
    end
    repeat (d) step();
    pll_locked = 1'b1;
    watch_release();
    check_release(tag);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    repeat (4) step();
    @(negedge refclk);
    checks++;
    if ({pll_rst, rst_out_n, ready, lock_fail, lock_lost, state_dbg} !==
        {1'b1, ALL_RST, 3'b000, ST_PLL_RST}) begin
      errors++;
      $display("FAIL reset outputs: got %b want %b",
               {pll_rst, rst_out_n, ready, lock_fail, lock_lost, state_dbg},
               {1'b1, ALL_RST, 3'b000, ST_PLL_RST});
    end
  endtask

  task automatic test_nominal();
    do_reset();
    run_to_run(500, "nominal");
  endtask

  // Lock seen by the FSM on the very edge the timeout would fire must still win.
  task automatic test_lock_at_timeout_edge();
    do_reset();
    run_to_run(LOCK_TIMEOUT - 3, "lock_at_timeout_edge");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_to_run($urandom_range(1, LOCK_TIMEOUT - 10), $sformatf("random%0d", i));
    end
  endtask

  task automatic test_timeout();
    int   rises[$];
    int   falls[$];
    int   fail_at;
    int   period;
    int   n;
    logic prev;
    do_reset();
    period  = PLL_RST_CYCLES + LOCK_TIMEOUT;
    prev    = 1'b1;
    fail_at = -1;
    for (int e = 1; e <= (MAX_RETRIES + 1) * period + 40; e++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (pll_rst && !prev) rises.push_back(e);
      if (!pll_rst && prev) falls.push_back(e);
      if (fail_at < 0 && lock_fail) fail_at = e;
      prev = pll_rst;
    end
    checks++;
    if (falls.size() != MAX_RETRIES + 1) begin
      errors++;
      $display("FAIL timeout pulse count: got %0d want %0d", falls.size(), MAX_RETRIES + 1);
    end
    for (int i = 0; i < falls.size() && i <= MAX_RETRIES; i++) begin
      checks++;
      if (falls[i] != PLL_RST_CYCLES + i * period) begin
        errors++;
        $display("FAIL timeout fall%0d edge: got %0d want %0d", i, falls[i], PLL_RST_CYCLES + i * period);
      end
    end
    checks++;
    if (rises.size() != MAX_RETRIES) begin
      errors++;
      $display("FAIL timeout retry count: got %0d want %0d", rises.size(), MAX_RETRIES);
    end
    for (int i = 0; i < rises.size() && i < MAX_RETRIES; i++) begin
      checks++;
      if (rises[i] != (i + 1) * period) begin
        errors++;
        $display("FAIL timeout rise%0d edge: got %0d want %0d", i, rises[i], (i + 1) * period);
      end
    end
    checks++;
    if (fail_at != (MAX_RETRIES + 1) * period) begin
      errors++;
      $display("FAIL lock_fail edge: got %0d want %0d", fail_at, (MAX_RETRIES + 1) * period);
    end
    checks++;
    if ({pll_rst, rst_out_n, ready, lock_fail, state_dbg} !== {1'b0, ALL_RST, 2'b01, ST_FAIL}) begin
      errors++;
      $display("FAIL fail state outputs: got %b want %b",
               {pll_rst, rst_out_n, ready, lock_fail, state_dbg}, {1'b0, ALL_RST, 2'b01, ST_FAIL});
    end
    // A held request parks the FSM in PLL_RST; the full pulse follows its release.
    step();
    sw_reset_req = 1'b1;
    repeat (20) step();
    @(negedge refclk);
    checks++;
    if ({pll_rst, lock_fail, state_dbg} !== {2'b10, ST_PLL_RST}) begin
      errors++;
      $display("FAIL sw held {pll_rst,fail,state}: got %b want %b",
               {pll_rst, lock_fail, state_dbg}, {2'b10, ST_PLL_RST});
    end
    step();
    sw_reset_req = 1'b0;
    count_pll_rst_high(n);
    checks++;
    if (n != PLL_RST_CYCLES) begin
      errors++;
      $display("FAIL pll_rst width after sw release: got %0d want %0d", n, PLL_RST_CYCLES);
    end
  endtask

  task automatic test_glitch();
    int n;
    int d;
    int g;
    do_reset();
    count_pll_rst_high(n);
    d = $urandom_range(1, 800);
    g = $urandom_range(5, 1000);
    repeat (d) step();
    pll_locked = 1'b1;
    repeat (g) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    watch_release();
    check_release($sformatf("glitch@%0d", g));
  endtask

  task automatic test_lock_drop();
    int n;
    do_reset();
    run_to_run(100, "drop_pre");
    step();
    pll_locked = 1'b0;
    @(posedge refclk);
    @(negedge refclk);
    @(posedge refclk);
    @(negedge refclk);
    checks++;
    if ({rst_out_n, ready, lock_lost} !== {ALL_REL, 2'b10}) begin
      errors++;
      $display("FAIL drop edge1 {rst_out_n,ready,lost}: got %b want %b",
               {rst_out_n, ready, lock_lost}, {ALL_REL, 2'b10});
    end
    @(posedge refclk);
    @(negedge refclk);
`ifdef PLL_LOCK_RECOVERY_EN
    checks++;
    if ({rst_out_n, ready, lock_lost, pll_rst} !== {ALL_RST, 3'b011}) begin
      errors++;
      $display("FAIL drop recovery {rst_out_n,ready,lost,pll_rst}: got %b want %b",
               {rst_out_n, ready, lock_lost, pll_rst}, {ALL_RST, 3'b011});
    end
    count_pll_rst_high(n);
    checks++;
    if (n + 1 != PLL_RST_CYCLES) begin
      errors++;
      $display("FAIL drop recovery pll_rst width: got %0d want %0d", n + 1, PLL_RST_CYCLES);
    end
`else
    checks++;
    if ({rst_out_n, ready, lock_lost, pll_rst, state_dbg} !== {ALL_REL, 3'b110, ST_RUN}) begin
      errors++;
      $display("FAIL drop hold {rst_out_n,ready,lost,pll_rst,state}: got %b want %b",
               {rst_out_n, ready, lock_lost, pll_rst, state_dbg}, {ALL_REL, 3'b110, ST_RUN});
    end
    repeat (50) step();
    pll_locked = 1'b1;
    repeat (10) step();
    @(negedge refclk);
    checks++;
    if ({rst_out_n, ready, lock_lost, pll_rst, state_dbg} !== {ALL_REL, 3'b110, ST_RUN}) begin
      errors++;
      $display("FAIL drop sticky {rst_out_n,ready,lost,pll_rst,state}: got %b want %b",
               {rst_out_n, ready, lock_lost, pll_rst, state_dbg}, {ALL_REL, 3'b110, ST_RUN});
    end
    n = 0;
`endif
  endtask

  task automatic test_rst_mid_release();
    int n;
    do_reset();
    count_pll_rst_high(n);
    repeat (50) step();
    pll_locked = 1'b1;
    for (int i = 0; i < 2 + STABLE_CYCLES + STAGE_GAP + 8; i++) begin
      @(negedge refclk);
      if (rst_out_n == FIRST_ONLY) break;
    end
    checks++;
    if (rst_out_n !== FIRST_ONLY) begin
      errors++;
      $display("FAIL mid release pattern: got %b want %b", rst_out_n, FIRST_ONLY);
    end
    repeat (5) @(negedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, rst_out_n, ready, state_dbg} !== {1'b1, ALL_RST, 1'b0, ST_PLL_RST}) begin
      errors++;
      $display("FAIL async reset {pll_rst,rst_out_n,ready,state}: got %b want %b",
               {pll_rst, rst_out_n, ready, state_dbg}, {1'b1, ALL_RST, 1'b0, ST_PLL_RST});
    end
    pll_locked = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    run_to_run($urandom_range(1, 1500), "after_async_reset");
  endtask

  task automatic test_sw_vs_lock();
    int n;
    do_reset();
    run_to_run(300, "sw_pre");
    step();
    pll_locked = 1'b0;
    step();
    step();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    @(negedge refclk);
    checks++;
    if ({pll_rst, rst_out_n, ready, lock_lost, lock_fail, state_dbg} !==
        {1'b1, ALL_RST, 3'b000, ST_PLL_RST}) begin
      errors++;
      $display("FAIL sw vs lock loss {pll_rst,rst_out_n,ready,lost,fail,state}: got %b want %b",
               {pll_rst, rst_out_n, ready, lock_lost, lock_fail, state_dbg},
               {1'b1, ALL_RST, 3'b000, ST_PLL_RST});
    end
    count_pll_rst_high(n);
    checks++;
    if (n + 1 != PLL_RST_CYCLES) begin
      errors++;
      $display("FAIL sw restart pll_rst width: got %0d want %0d", n + 1, PLL_RST_CYCLES);
    end
    repeat (200) step();
    pll_locked = 1'b1;
    watch_release();
    check_release("sw_restart");
  endtask

  initial begin
    #(4000000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_at_timeout_edge();
    test_random();
    test_timeout();
    test_glitch();
    test_lock_drop();
    test_rst_mid_release();
    test_sw_vs_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
